// File: rtl/rf_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter_if
// Description : Bundles the signals of the register-file write arbiter:
//               pipeline retire request, multi-cycle source handshake,
//               register-file write port and occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_write_arbiter_if #(
    parameter int DEPTH = 2
);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    // Pipeline retire path
    logic               pipe_we_i;
    logic [4:0]         pipe_rd_i;
    logic [31:0]        pipe_data_i;
    logic               pipe_stall_o;

    // Multi-cycle result source
    logic               mc_valid_i;
    logic               mc_ready_o;
    logic [4:0]         mc_rd_i;
    logic [31:0]        mc_data_i;

    // Register-file write port
    logic               rf_we_o;
    logic [4:0]         rf_rd_o;
    logic [31:0]        rf_data_o;

    // Pending FIFO occupancy
    logic [c_cnt_w-1:0] pend_count_o;

    // Requester side: drives requests, observes grants
    modport master (
        output pipe_we_i, pipe_rd_i, pipe_data_i,
        output mc_valid_i, mc_rd_i, mc_data_i,
        input  pipe_stall_o, mc_ready_o,
        input  rf_we_o, rf_rd_o, rf_data_o, pend_count_o
    );

    // Arbiter side
    modport slave (
        input  pipe_we_i, pipe_rd_i, pipe_data_i,
        input  mc_valid_i, mc_rd_i, mc_data_i,
        output pipe_stall_o, mc_ready_o,
        output rf_we_o, rf_rd_o, rf_data_o, pend_count_o
    );
endinterface
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Shares the write-back register-file write port between the
//               in-order pipeline (priority, no back-pressure) and a
//               multi-cycle result source buffered in a small pending FIFO.
//               Drops x0 writes, kills older pending writes on WAW and
//               stalls the pipeline for one cycle to avoid FIFO starvation.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    rf_write_arbiter_if.slave  bus
);
    localparam int c_addr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w  = $clog2(DEPTH) + 1;
    localparam int c_wait_w = $clog2(MAX_WAIT + 1);

    localparam logic [c_cnt_w-1:0]  c_full     = c_cnt_w'(DEPTH);
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(MAX_WAIT);

    // Pending FIFO storage and state
    logic [4:0]          r_rd_q   [DEPTH];
    logic [31:0]         r_data_q [DEPTH];
    logic [DEPTH-1:0]    r_kill_q;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0]  r_count;

    // Starvation tracking and registered outputs
    logic [c_wait_w-1:0] r_wait;
    logic                r_stall;
    logic                r_rf_we;
    logic [4:0]          r_rf_rd;
    logic [31:0]         r_rf_data;

    logic                w_ready;
    logic                w_push;
    logic                w_peff;
    logic                w_head_vld;
    logic                w_head_kill;
    logic                w_pop_live;
    logic                w_pop_kill;
    logic                w_pop;
    logic                w_push_kill;
    logic [c_wait_w-1:0] w_wait_nxt;
    logic                w_stall_nxt;

    // Handshake, grant and pop decisions for the current cycle
    always_comb begin
        // Occupancy before any pop this cycle; no pop-to-push bypass
        w_ready     = !rst_i && (r_count < c_full);
        // x0 results are accepted but never stored
        w_push      = bus.mc_valid_i && w_ready && (bus.mc_rd_i != 5'd0);
        w_peff      = bus.pipe_we_i && !r_stall && (bus.pipe_rd_i != 5'd0);
        w_head_vld  = (r_count != '0);
        w_head_kill = r_kill_q[r_rd_ptr];
        w_pop_live  = !w_peff && w_head_vld && !w_head_kill;
        // Killed heads drain regardless of the pipeline grant
        w_pop_kill  = w_head_vld && w_head_kill;
        w_pop       = w_pop_live || w_pop_kill;
        // A same-cycle younger pipeline write to the same rd supersedes it
        w_push_kill = w_peff && (bus.mc_rd_i == bus.pipe_rd_i);
    end

    // Wait counter and stall decision for the next cycle
    always_comb begin
        w_wait_nxt  = r_wait;
        w_stall_nxt = 1'b0;
        if (!w_head_vld || w_head_kill || w_pop_live) begin
            w_wait_nxt = '0;
        end else if (r_wait != c_wait_max) begin
            w_wait_nxt = r_wait + 1'b1;
        end
        // One stall cycle guarantees the head a slot; never two in a row
        w_stall_nxt = !r_stall && (r_wait == c_wait_max) &&
                      w_head_vld && !w_head_kill && !w_pop_live;
    end

    // FIFO pointers, occupancy and kill flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_kill_q <= '0;
        end else begin
            // Stale slots may be marked too; a push rewrites the flag
            if (w_peff) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_rd_q[i] == bus.pipe_rd_i) begin
                        r_kill_q[i] <= 1'b1;
                    end
                end
            end
            if (w_push) begin
                r_kill_q[r_wr_ptr] <= w_push_kill;
                r_wr_ptr           <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO payload storage; contents are meaningless until pushed
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_rd_q[r_wr_ptr]   <= bus.mc_rd_i;
            r_data_q[r_wr_ptr] <= bus.mc_data_i;
        end
    end

    // Starvation counter and registered pipeline stall
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wait  <= '0;
            r_stall <= 1'b0;
        end else begin
            r_wait  <= w_wait_nxt;
            r_stall <= w_stall_nxt;
        end
    end

    // Registered register-file write port
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rf_we   <= 1'b0;
            r_rf_rd   <= '0;
            r_rf_data <= '0;
        end else begin
            r_rf_we <= w_peff || w_pop_live;
            if (w_peff) begin
                r_rf_rd   <= bus.pipe_rd_i;
                r_rf_data <= bus.pipe_data_i;
            end else if (w_pop_live) begin
                r_rf_rd   <= r_rd_q[r_rd_ptr];
                r_rf_data <= r_data_q[r_rd_ptr];
            end
        end
    end

    assign bus.mc_ready_o   = w_ready;
    assign bus.pipe_stall_o = r_stall;
    assign bus.rf_we_o      = r_rf_we;
    assign bus.rf_rd_o      = r_rf_rd;
    assign bus.rf_data_o    = r_rf_data;
    assign bus.pend_count_o = r_count;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Directed self-checking bench for rf_write_arbiter
//               (DEPTH=2, MAX_WAIT=4) with an in-order write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_write_arbiter_if #(.DEPTH(2)) bus ();

    rf_write_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    wr_t   exp_q[$];
    wr_t   mon_e;
    int    vectors     = 0;
    int    miscompares = 0;

    logic [4:0]  mc_rd_tab  [3];
    logic [31:0] mc_dat_tab [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
        wr_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every register-file write must match the oldest expected write
    always @(negedge clk) begin
        if (bus.rf_we_o === 1'b1) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_write: observed rd %0d data %0h expected no write",
                       bus.rf_rd_o, bus.rf_data_o);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("wr_rd", 32'(bus.rf_rd_o), 32'(mon_e.rd));
                check("wr_data", bus.rf_data_o, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   sent, mc_idx, c, stall_cycles, acc6_cycle;
        logic s, r, v, pw, prev_stall;

        mc_rd_tab[0] = 5'd3; mc_dat_tab[0] = 32'hA3A3_0003;
        mc_rd_tab[1] = 5'd4; mc_dat_tab[1] = 32'hA4A4_0004;
        mc_rd_tab[2] = 5'd6; mc_dat_tab[2] = 32'hA6A6_0006;

        rst             = 1'b1;
        bus.pipe_we_i   = 1'b0;
        bus.pipe_rd_i   = '0;
        bus.pipe_data_i = '0;
        bus.mc_valid_i  = 1'b0;
        bus.mc_rd_i     = '0;
        bus.mc_data_i   = '0;

        // ---------------- reset state
        tick();
        tick();
        check("ready_in_reset", 32'(bus.mc_ready_o), 0);
        check("reset_we", 32'(bus.rf_we_o), 0);
        check("reset_rd", 32'(bus.rf_rd_o), 0);
        check("reset_data", bus.rf_data_o, 0);
        check("reset_stall", 32'(bus.pipe_stall_o), 0);
        check("reset_count", 32'(bus.pend_count_o), 0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", 32'(bus.mc_ready_o), 1);

        // ---------------- pipeline only, then x0 write dropped
        bus.pipe_we_i   = 1'b1;
        bus.pipe_rd_i   = 5'd5;
        bus.pipe_data_i = 32'hDEAD_BEEF;
        expect_wr(5'd5, 32'hDEAD_BEEF);
        tick();
        check("pipe_we", 32'(bus.rf_we_o), 1);
        bus.pipe_rd_i   = 5'd0;
        bus.pipe_data_i = 32'h0BAD_0BAD;
        tick();
        check("pipe_x0_we", 32'(bus.rf_we_o), 0);
        bus.pipe_we_i   = 1'b0;

        // ---------------- multi-cycle only, idle pipeline
        bus.mc_valid_i = 1'b1;
        bus.mc_rd_i    = 5'd7;
        bus.mc_data_i  = 32'h1234_5678;
        check("mc_ready_empty", 32'(bus.mc_ready_o), 1);
        expect_wr(5'd7, 32'h1234_5678);
        tick();
        bus.mc_valid_i = 1'b0;
        check("mc_count_t1", 32'(bus.pend_count_o), 1);
        check("mc_we_t1", 32'(bus.rf_we_o), 0);
        tick();
        check("mc_we_t2", 32'(bus.rf_we_o), 1);
        check("mc_count_t2", 32'(bus.pend_count_o), 0);

        // multi-cycle x0 result is consumed without being stored
        bus.mc_valid_i = 1'b1;
        bus.mc_rd_i    = 5'd0;
        bus.mc_data_i  = 32'h5555_AAAA;
        tick();
        bus.mc_valid_i = 1'b0;
        check("mc_x0_count", 32'(bus.pend_count_o), 0);
        tick();
        check("mc_x0_we", 32'(bus.rf_we_o), 0);

        // ---------------- full FIFO and starvation stall
        for (int k = 0; k < 6; k++) expect_wr(5'd20, 32'h1000_0000 + k);
        expect_wr(5'd3, 32'hA3A3_0003);
        expect_wr(5'd20, 32'h1000_0006);
        expect_wr(5'd20, 32'h1000_0007);
        expect_wr(5'd4, 32'hA4A4_0004);
        expect_wr(5'd6, 32'hA6A6_0006);
        sent = 0; mc_idx = 0; c = 0; stall_cycles = 0; acc6_cycle = -1;
        prev_stall = 1'b0;
        while ((sent < 8 || mc_idx < 3) && c < 40) begin
            bus.pipe_we_i   = (sent < 8);
            bus.pipe_rd_i   = 5'd20;
            bus.pipe_data_i = 32'h1000_0000 + sent;
            bus.mc_valid_i  = (mc_idx < 3);
            bus.mc_rd_i     = mc_rd_tab[(mc_idx < 3) ? mc_idx : 2];
            bus.mc_data_i   = mc_dat_tab[(mc_idx < 3) ? mc_idx : 2];
            #1;
            if (c == 2) check("ready_full", 32'(bus.mc_ready_o), 0);
            s  = bus.pipe_stall_o;
            r  = bus.mc_ready_o;
            v  = bus.mc_valid_i;
            pw = bus.pipe_we_i;
            if (s) begin
                stall_cycles++;
                check("stall_cycle", c, 6);
            end
            check("stall_back_to_back", 32'(prev_stall && s), 0);
            tick();
            if (pw && !s) sent++;
            if (v && r) begin
                if (mc_idx == 2) acc6_cycle = c;
                mc_idx++;
            end
            prev_stall = s;
            c++;
        end
        bus.pipe_we_i  = 1'b0;
        bus.mc_valid_i = 1'b0;
        check("stream_done", 32'(c < 40), 1);
        check("stall_count", stall_cycles, 1);
        check("held_accept_cycle", acc6_cycle, 7);
        repeat (4) tick();
        check("drain_count", 32'(bus.pend_count_o), 0);
        check("drain_scoreboard", exp_q.size(), 0);

        // ---------------- WAW: pending entry killed by younger pipe write
        bus.mc_valid_i = 1'b1;
        bus.mc_rd_i    = 5'd9;
        bus.mc_data_i  = 32'h0000_0001;
        tick();
        bus.mc_valid_i  = 1'b0;
        check("waw_count_a", 32'(bus.pend_count_o), 1);
        bus.pipe_we_i   = 1'b1;
        bus.pipe_rd_i   = 5'd9;
        bus.pipe_data_i = 32'h0000_0002;
        expect_wr(5'd9, 32'h0000_0002);
        tick();
        bus.pipe_we_i = 1'b0;
        check("waw_we", 32'(bus.rf_we_o), 1);
        check("waw_count_b", 32'(bus.pend_count_o), 1);
        tick();
        check("waw_count_c", 32'(bus.pend_count_o), 0);
        check("waw_silent_pop", 32'(bus.rf_we_o), 0);
        tick();
        check("waw_no_late_write", 32'(bus.rf_we_o), 0);

        // WAW with the matching result arriving in the same cycle
        bus.mc_valid_i  = 1'b1;
        bus.mc_rd_i     = 5'd12;
        bus.mc_data_i   = 32'h0000_0005;
        bus.pipe_we_i   = 1'b1;
        bus.pipe_rd_i   = 5'd12;
        bus.pipe_data_i = 32'h0000_0006;
        expect_wr(5'd12, 32'h0000_0006);
        tick();
        bus.mc_valid_i = 1'b0;
        bus.pipe_we_i  = 1'b0;
        check("waw_same_count_a", 32'(bus.pend_count_o), 1);
        tick();
        check("waw_same_count_b", 32'(bus.pend_count_o), 0);
        check("waw_same_silent", 32'(bus.rf_we_o), 0);

        // ---------------- reset with two pending entries
        bus.pipe_we_i   = 1'b1;
        bus.pipe_rd_i   = 5'd21;
        bus.pipe_data_i = 32'h2100_0000;
        bus.mc_valid_i  = 1'b1;
        bus.mc_rd_i     = 5'd13;
        bus.mc_data_i   = 32'hCCCC_0013;
        expect_wr(5'd21, 32'h2100_0000);
        tick();
        bus.pipe_data_i = 32'h2100_0001;
        bus.mc_rd_i     = 5'd14;
        bus.mc_data_i   = 32'hCCCC_0014;
        expect_wr(5'd21, 32'h2100_0001);
        tick();
        check("rst_pre_count", 32'(bus.pend_count_o), 2);
        rst            = 1'b1;
        bus.pipe_we_i  = 1'b0;
        bus.mc_valid_i = 1'b0;
        #1;
        check("rst_ready_forced", 32'(bus.mc_ready_o), 0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_we", 32'(bus.rf_we_o), 0);
        check("rst_rd", 32'(bus.rf_rd_o), 0);
        check("rst_data", bus.rf_data_o, 0);
        check("rst_stall", 32'(bus.pipe_stall_o), 0);
        check("rst_count", 32'(bus.pend_count_o), 0);
        check("rst_ready", 32'(bus.mc_ready_o), 1);
        repeat (4) tick();
        check("rst_idle_we", 32'(bus.rf_we_o), 0);
        check("rst_idle_count", 32'(bus.pend_count_o), 0);
        check("final_scoreboard", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port in the write-back stage between two requesters.
- Requester 1 is the in-order pipeline retire path. It has priority and cannot be back-pressured.
- Requester 2 is a multi-cycle result source (e.g. a future mul/div or a slow load unit). It uses a valid/ready handshake and a small pending FIFO.
- Additional duties: drops x0 writes, resolves write-after-write (WAW) against pending entries, and stalls the pipeline to prevent starvation.

Parameters:
- DEPTH, 2, pending FIFO entries for the multi-cycle source (power of 2, >=2).
- MAX_WAIT, 4, cycles a non-empty FIFO head may wait before the pipeline is stalled (>=1).

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- pipe_we_i  in  1  pipeline retire write request
- pipe_rd_i  in  5  pipeline destination register
- pipe_data_i  in  32  pipeline write data
- pipe_stall_o  out  1  registered; pipeline must hold its retire request, and arbiter ignores pipe_we_i while high
- mc_valid_i  in  1  multi-cycle result valid
- mc_ready_o  out  1  arbiter can accept a multi-cycle result
- mc_rd_i  in  5  multi-cycle destination register
- mc_data_i  in  32  multi-cycle result data
- rf_we_o  out  1  registered register-file write enable
- rf_rd_o  out  5  registered write address
- rf_data_o  out  32  registered write data
- pend_count_o  out  $clog2(DEPTH)+1  live FIFO occupancy, including killed entries

Behaviour:
- Reset (rst_i high at a clock edge):
  - FIFO emptied; wait counter cleared.
  - rf_we_o/rf_rd_o/rf_data_o = 0, pipe_stall_o = 0, pend_count_o = 0.
  - mc_ready_o is forced 0 while rst_i is high.
  - Reset mid-transfer discards all pending entries without writing them.
- Handshake:
  - mc_ready_o = (count < DEPTH). Uses pre-pop occupancy; there is no same-cycle pop-to-push bypass.
  - Transfer occurs when mc_valid_i && mc_ready_o.
  - An accepted entry with mc_rd_i == 0 is consumed but not enqueued.
- Effective pipeline request: peff = pipe_we_i && !pipe_stall_o && pipe_rd_i != 0.
- Grant, per cycle, in priority order:
  1. If peff: pipeline granted.
  2. Else if the FIFO head is valid and not killed: head popped and granted.
  3. Else: no write.
- Killed heads are popped silently in any cycle, including cycles where the pipeline is granted. They never drive rf_we_o.
  - A killed head and a live head are never both popped in one cycle; at most one pop per cycle.
- Latency:
  - Pipeline grant at cycle T gives rf_we_o high at T+1 with the captured rd/data.
  - Multi-cycle accept at T (FIFO empty, pipeline idle) gives a pop at T+1 and rf_we_o at T+2.
- WAW rule (the pipeline write is younger):
  - When the pipeline is granted with rd R, every valid FIFO entry with rd == R is marked killed that cycle.
  - An entry being accepted in that same cycle with mc_rd_i == R is enqueued already killed.
- Starvation counter:
  - wait_cnt increments each cycle the FIFO holds a live head that is not popped, saturating at MAX_WAIT.
  - It clears on a live-head pop or when the FIFO becomes empty or its head is killed.
  - pipe_stall_o is registered and goes high the cycle after wait_cnt reaches MAX_WAIT.
  - In a stall cycle the live head is guaranteed the port and popped. pipe_stall_o and wait_cnt then clear next cycle.
  - pipe_stall_o never stays high for 2 consecutive cycles.
- FIFO pointers wrap modulo DEPTH. Occupancy is never > DEPTH or < 0; with simultaneous push and pop it is unchanged.
- rf_we_o is 0 in every cycle without a grant. rf_rd_o/rf_data_o then hold their last values and are don't-care.

Test Plan:
- Pipe only: pipe_we_i=1, rd=5, data=0xDEADBEEF at T -> rf_we_o=1, rd=5, data=0xDEADBEEF at T+1. Then pipe rd=0 -> rf_we_o=0.
- MC only, idle pipe: accept rd=7, data=0x12345678 at T -> pend_count_o=1 at T+1, rf_we_o with rd=7 at T+2, pend_count_o=0 at T+2.
- Full FIFO: DEPTH=2, pipe writing every cycle, two MC accepts -> mc_ready_o=0. A third mc_valid_i is held unaccepted until a pop.
- Starvation: MAX_WAIT=4, pipe writes continuously, one MC entry rd=3 -> pipe_stall_o high for exactly 1 cycle. That cycle rd=3 is popped and written next cycle; the held pipe write lands afterwards, none lost.
- WAW: MC entry rd=9, data=0x1 pending; pipe writes rd=9, data=0x2 -> only 0x2 is written to x9. The killed entry is popped silently and pend_count_o returns to 0.
- Reset mid-operation: 2 pending entries, rst_i=1 for 1 cycle -> all outputs 0, no rf writes of pending data afterwards, mc_ready_o=1 on the first cycle after reset.
